// File: rtl/mpt_response_stage_if.sv
// Shared MPT transaction types plus the slave-side / response-side handshake
// bundle of the MPT walker response stage.
package mpt_rsp_pkg;

  typedef enum logic [2:0] {
    NO_ERROR       = 3'd0,
    NOT_VALID_ADDR = 3'd1,
    RESERVED_BITS  = 3'd2,
    LEVEL_OVERFLOW = 3'd3,
    ILLEGAL_PERM   = 3'd4
  } page_format_fault_e;

  typedef enum logic [1:0] {
    MPT_WALKING_IDLE   = 2'd0,
    MPT_WALKING_ACTIVE = 2'd1,
    MPT_WALKING_SKIP   = 2'd2,
    MPT_WALKING_DONE   = 2'd3
  } mpt_walking_e;

  // 32-bit completed walk record; valid = 0 marks a pipeline bubble.
  typedef struct packed {
    logic               valid;
    mpt_walking_e       walking;
    logic               access_error;
    page_format_fault_e format_error;
    logic [24:0]        payload;
  } mptw_transaction_t;

endpackage

interface mpt_response_stage_if #(
  parameter int PIPELINE_SLAVE_DATA_WIDTH = 32
);

  logic                                 stage_slave_valid;
  logic                                 stage_slave_ready;
  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0] stage_slave_data;

  logic                                 rsp_valid_o;
  logic                                 rsp_ready_i;
  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0] rsp_data_o;
  logic                                 rsp_allow_o;

  // The environment: drives pipeline words in and consumes responses.
  modport master (
    output stage_slave_valid,
    input  stage_slave_ready,
    output stage_slave_data,
    input  rsp_valid_o,
    output rsp_ready_i,
    input  rsp_data_o,
    input  rsp_allow_o
  );

  // The response stage itself.
  modport slave (
    input  stage_slave_valid,
    output stage_slave_ready,
    input  stage_slave_data,
    output rsp_valid_o,
    input  rsp_ready_i,
    output rsp_data_o,
    output rsp_allow_o
  );

endinterface

// File: rtl/mpt_response_stage.sv
// MPT walker tail stage: response FIFO, allow/deny decision and sticky fault record.
// Define MPT_RSP_STATS_EN to build the allowed/denied response counters.
module mpt_response_stage
  import mpt_rsp_pkg::*;
#(
  parameter int PIPELINE_SLAVE_DATA_WIDTH = 32,
  parameter int RSP_FIFO_DEPTH            = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  mpt_response_stage_if.slave       bus,
  input  logic                      flush_i,
  output logic                      exception_valid_o,
  output page_format_fault_e        exception_cause_o,
  output logic                      exception_access_o,
  input  logic                      exception_ack_i,
  output logic [7:0]                overflow_cnt_o,
  output logic [31:0]               stat_allow_cnt_o,
  output logic [31:0]               stat_deny_cnt_o
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    EXC_IDLE = 1'b0,
    EXC_HOLD = 1'b1
  } exc_state_e;

  mptw_transaction_t fifo_data [RSP_FIFO_DEPTH];
  logic [RSP_FIFO_DEPTH-1:0] fifo_allow;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  mptw_transaction_t in_txn;
  mptw_transaction_t head_txn;
  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0] head_word;
  logic head_allow;
  logic in_allow;
  logic fifo_full;
  logic fifo_empty;
  logic slave_ready;
  logic rsp_valid;
  logic push;
  logic pop;
  logic pop_fault;

  exc_state_e         state_q;
  exc_state_e         state_d;
  page_format_fault_e cause_q;
  page_format_fault_e cause_d;
  logic               access_q;
  logic               access_d;
  logic [7:0]         ovf_q;
  logic [7:0]         ovf_d;

  assign in_txn     = mptw_transaction_t'(bus.stage_slave_data);
  assign fifo_full  = (count == CNT_W'(RSP_FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Reset and flush cycles neither accept nor hand out words, so no handshake
  // can complete while the contents are being discarded.
  assign slave_ready = !fifo_full && !flush_i && !rst_i;
  assign rsp_valid   = !fifo_empty && !flush_i && !rst_i;

  assign push = bus.stage_slave_valid && slave_ready && in_txn.valid;
  assign pop  = rsp_valid && bus.rsp_ready_i;

  assign in_allow = (in_txn.format_error == NO_ERROR) &&
                    !in_txn.access_error &&
                    (in_txn.walking != MPT_WALKING_SKIP);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wr_ptr]  <= in_txn;
      fifo_allow[wr_ptr] <= in_allow;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_txn   = fifo_data[rd_ptr];
  assign head_word  = head_txn;
  assign head_allow = fifo_allow[rd_ptr];

  assign bus.stage_slave_ready = slave_ready;
  assign bus.rsp_valid_o       = rsp_valid;
  assign bus.rsp_data_o        = fifo_empty ? '0 : head_word;
  assign bus.rsp_allow_o       = fifo_empty ? 1'b0 : head_allow;

  // A skip-denied response is not a fault; only format/access errors are recorded.
  assign pop_fault = pop && ((head_txn.format_error != NO_ERROR) || head_txn.access_error);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q  <= EXC_IDLE;
      cause_q  <= NO_ERROR;
      access_q <= 1'b0;
      ovf_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      access_q <= access_d;
      ovf_q    <= ovf_d;
    end
  end

  // An ack frees the record, so a fault popped alongside it takes the slot at once.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    access_d = access_q;
    ovf_d    = ovf_q;
    case (state_q)
      EXC_IDLE: begin
        if (pop_fault) begin
          state_d  = EXC_HOLD;
          cause_d  = head_txn.format_error;
          access_d = head_txn.access_error;
        end
      end
      EXC_HOLD: begin
        if (exception_ack_i) begin
          if (pop_fault) begin
            cause_d  = head_txn.format_error;
            access_d = head_txn.access_error;
          end else begin
            state_d  = EXC_IDLE;
            cause_d  = NO_ERROR;
            access_d = 1'b0;
          end
        end else if (pop_fault && (ovf_q != 8'hFF)) begin
          ovf_d = ovf_q + 8'd1;
        end
      end
      default: begin
        state_d = EXC_IDLE;
      end
    endcase
  end

  assign exception_valid_o  = (state_q == EXC_HOLD);
  assign exception_cause_o  = cause_q;
  assign exception_access_o = access_q;
  assign overflow_cnt_o     = ovf_q;

`ifdef MPT_RSP_STATS_EN
  logic [31:0] allow_cnt_q;
  logic [31:0] deny_cnt_q;

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      allow_cnt_q <= 32'd0;
      deny_cnt_q  <= 32'd0;
    end else if (pop) begin
      if (head_allow && (allow_cnt_q != 32'hFFFF_FFFF)) begin
        allow_cnt_q <= allow_cnt_q + 32'd1;
      end
      if (!head_allow && (deny_cnt_q != 32'hFFFF_FFFF)) begin
        deny_cnt_q <= deny_cnt_q + 32'd1;
      end
    end
  end

  assign stat_allow_cnt_o = allow_cnt_q;
  assign stat_deny_cnt_o  = deny_cnt_q;
`else
  assign stat_allow_cnt_o = 32'd0;
  assign stat_deny_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_mpt_response_stage.sv
// Self-checking bench for mpt_response_stage: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mpt_response_stage;
  import mpt_rsp_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               flush_i;
  logic               exception_ack_i;
  logic               exception_valid_o;
  page_format_fault_e exception_cause_o;
  logic               exception_access_o;
  logic [7:0]         overflow_cnt_o;
  logic [31:0]        stat_allow_cnt_o;
  logic [31:0]        stat_deny_cnt_o;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  mpt_response_stage_if #(.PIPELINE_SLAVE_DATA_WIDTH(DATA_W)) bus ();

  mpt_response_stage #(
    .PIPELINE_SLAVE_DATA_WIDTH(DATA_W),
    .RSP_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus),
    .flush_i(flush_i),
    .exception_valid_o(exception_valid_o),
    .exception_cause_o(exception_cause_o),
    .exception_access_o(exception_access_o),
    .exception_ack_i(exception_ack_i),
    .overflow_cnt_o(overflow_cnt_o),
    .stat_allow_cnt_o(stat_allow_cnt_o),
    .stat_deny_cnt_o(stat_deny_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] make_word(input bit v, input mpt_walking_e w, input bit acc,
                                            input page_format_fault_e fmt, input logic [24:0] pl);
    mptw_transaction_t t;
    t.valid        = v;
    t.walking      = w;
    t.access_error = acc;
    t.format_error = fmt;
    t.payload      = pl;
    return t;
  endfunction

  function automatic bit word_allowed(input logic [31:0] w);
    mptw_transaction_t t = w;
    return (t.format_error == NO_ERROR) && !t.access_error && (t.walking != MPT_WALKING_SKIP);
  endfunction

  function automatic bit word_faults(input logic [31:0] w);
    mptw_transaction_t t = w;
    return (t.format_error != NO_ERROR) || t.access_error;
  endfunction

  function automatic logic [31:0] random_word();
    page_format_fault_e fmt;
    fmt = ($urandom_range(0, 4) == 0) ? page_format_fault_e'($urandom_range(1, 4)) : NO_ERROR;
    return make_word($urandom_range(0, 4) != 0, mpt_walking_e'($urandom_range(0, 3)),
                     $urandom_range(0, 5) == 0, fmt, 25'($urandom));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle with the given inputs; returns at the falling edge of that cycle.
  task automatic applyStimulus(input bit rst, input bit sv, input logic [31:0] sd,
                               input bit rr, input bit fl, input bit ak);
    @(posedge clk_i);
    #1;
    rst_i                 = rst;
    bus.stage_slave_valid = sv;
    bus.stage_slave_data  = sd;
    bus.rsp_ready_i       = rr;
    flush_i               = fl;
    exception_ack_i       = ak;
    @(negedge clk_i);
  endtask

  task automatic idle(input bit rr);
    applyStimulus(1'b0, 1'b0, 32'd0, rr, 1'b0, 1'b0);
  endtask

  task automatic push_word(input logic [31:0] w, input bit rr);
    applyStimulus(1'b0, 1'b1, w, rr, 1'b0, 1'b0);
  endtask

  // Reference model: an ordered list of pending responses plus the fault record.
  logic [31:0]        model_q[$];
  bit                 m_exc_valid = 1'b0;
  page_format_fault_e m_cause     = NO_ERROR;
  bit                 m_access    = 1'b0;
  int                 m_ovf       = 0;
  longint             m_allow     = 0;
  longint             m_deny      = 0;
  bit                 exp_ready;
  bit                 exp_valid;
  logic [31:0]        exp_data;
  bit                 exp_allow;
  logic [31:0]        popped;
  mptw_transaction_t  in_t;

  always @(negedge clk_i) begin
    if (armed) begin
      exp_ready = !rst_i && !flush_i && (model_q.size() < DEPTH);
      exp_valid = !rst_i && !flush_i && (model_q.size() != 0);
      exp_data  = (model_q.size() != 0) ? model_q[0] : 32'd0;
      exp_allow = (model_q.size() != 0) ? word_allowed(model_q[0]) : 1'b0;

      checkOutput("stage_slave_ready", 32'(bus.stage_slave_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_valid));
      checkOutput("rsp_data", bus.rsp_data_o, exp_data);
      checkOutput("rsp_allow", 32'(bus.rsp_allow_o), 32'(exp_allow));
      checkOutput("exception_valid", 32'(exception_valid_o), 32'(m_exc_valid));
      checkOutput("exception_cause", 32'(exception_cause_o), 32'(m_cause));
      checkOutput("exception_access", 32'(exception_access_o), 32'(m_access));
      checkOutput("overflow_cnt", 32'(overflow_cnt_o), 32'(m_ovf));
`ifdef MPT_RSP_STATS_EN
      checkOutput("stat_allow", stat_allow_cnt_o, 32'(m_allow));
      checkOutput("stat_deny", stat_deny_cnt_o, 32'(m_deny));
`else
      checkOutput("stat_allow", stat_allow_cnt_o, 32'd0);
      checkOutput("stat_deny", stat_deny_cnt_o, 32'd0);
`endif

      if (rst_i) begin
        model_q.delete();
        m_exc_valid = 1'b0;
        m_cause     = NO_ERROR;
        m_access    = 1'b0;
        m_ovf       = 0;
        m_allow     = 0;
        m_deny      = 0;
      end else if (flush_i) begin
        model_q.delete();
        m_exc_valid = 1'b0;
        m_cause     = NO_ERROR;
        m_access    = 1'b0;
        m_ovf       = 0;
      end else begin
        if (exp_valid && bus.rsp_ready_i) begin
          popped = model_q.pop_front();
          in_t   = popped;
          if (word_allowed(popped)) m_allow = (m_allow < 64'hFFFF_FFFF) ? m_allow + 1 : m_allow;
          else                      m_deny  = (m_deny  < 64'hFFFF_FFFF) ? m_deny + 1 : m_deny;
          if (word_faults(popped)) begin
            if (m_exc_valid && !exception_ack_i) begin
              m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
            end else begin
              m_exc_valid = 1'b1;
              m_cause     = in_t.format_error;
              m_access    = in_t.access_error;
            end
          end else if (m_exc_valid && exception_ack_i) begin
            m_exc_valid = 1'b0;
            m_cause     = NO_ERROR;
            m_access    = 1'b0;
          end
        end else if (m_exc_valid && exception_ack_i) begin
          m_exc_valid = 1'b0;
          m_cause     = NO_ERROR;
          m_access    = 1'b0;
        end
        in_t = bus.stage_slave_data;
        if (bus.stage_slave_valid && exp_ready && in_t.valid) model_q.push_back(bus.stage_slave_data);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] w1;
  logic [31:0] words[5];
  logic [31:0] got_w[$];
  logic [31:0] f1, f2, f3;
  bit          pending5;

  initial begin
    rst_i                 = 1'b1;
    bus.stage_slave_valid = 1'b0;
    bus.stage_slave_data  = 32'd0;
    bus.rsp_ready_i       = 1'b0;
    flush_i               = 1'b0;
    exception_ack_i       = 1'b0;
    @(posedge clk_i);
    armed = 1'b1;

    // Reset state
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("reset_ready", 32'(bus.stage_slave_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("reset_rsp_data", bus.rsp_data_o, 32'd0);
    checkOutput("reset_exc_valid", 32'(exception_valid_o), 32'd0);
    checkOutput("reset_ovf", 32'(overflow_cnt_o), 32'd0);

    // Single allowed word: visible one cycle after the push, gone after the pop
    w1 = make_word(1'b1, MPT_WALKING_DONE, 1'b0, NO_ERROR, 25'h0ABCDE);
    push_word(w1, 1'b1);
    checkOutput("t1_no_comb_path", 32'(bus.rsp_valid_o), 32'd0);
    idle(1'b1);
    checkOutput("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    checkOutput("t1_rsp_allow", 32'(bus.rsp_allow_o), 32'd1);
    checkOutput("t1_rsp_data", bus.rsp_data_o, w1);
    idle(1'b1);
    checkOutput("t1_empty_after_pop", 32'(bus.rsp_valid_o), 32'd0);

    // Fill to depth with the requester stalled, then drain in order
    for (int i = 0; i < 5; i++) words[i] = make_word(1'b1, MPT_WALKING_DONE, 1'b0, NO_ERROR, 25'(i + 1));
    for (int i = 0; i < 4; i++) push_word(words[i], 1'b0);
    push_word(words[4], 1'b0);
    checkOutput("t2_full_ready", 32'(bus.stage_slave_ready), 32'd0);
    checkOutput("t2_head_stable", bus.rsp_data_o, words[0]);
    push_word(words[4], 1'b0);
    checkOutput("t2_head_stable2", bus.rsp_data_o, words[0]);
    pending5 = 1'b1;
    for (int c = 0; c < 20 && got_w.size() < 5; c++) begin
      applyStimulus(1'b0, pending5, words[4], 1'b1, 1'b0, 1'b0);
      if (bus.rsp_valid_o) got_w.push_back(bus.rsp_data_o);
      if (pending5 && bus.stage_slave_ready) pending5 = 1'b0;
    end
    checkOutput("t2_drain_count", 32'(got_w.size()), 32'd5);
    for (int i = 0; i < got_w.size(); i++) checkOutput("t2_drain_order", got_w[i], words[i]);
    idle(1'b1);

    // Bubble: consumed, never answered
    push_word(make_word(1'b0, MPT_WALKING_DONE, 1'b0, NO_ERROR, 25'h1234), 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checkOutput("t3_bubble_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    end

    // Three faults without ack: first one recorded, two counted as overflow
    f1 = make_word(1'b1, MPT_WALKING_DONE, 1'b0, NOT_VALID_ADDR, 25'h11);
    f2 = make_word(1'b1, MPT_WALKING_DONE, 1'b1, NO_ERROR, 25'h22);
    f3 = make_word(1'b1, MPT_WALKING_ACTIVE, 1'b0, RESERVED_BITS, 25'h33);
    push_word(f1, 1'b1);
    push_word(f2, 1'b1);
    push_word(f3, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    checkOutput("t4_exc_valid", 32'(exception_valid_o), 32'd1);
    checkOutput("t4_exc_cause", 32'(exception_cause_o), 32'(NOT_VALID_ADDR));
    checkOutput("t4_exc_access", 32'(exception_access_o), 32'd0);
    checkOutput("t4_overflow", 32'(overflow_cnt_o), 32'd2);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("t4_ack_clears", 32'(exception_valid_o), 32'd0);
    checkOutput("t4_ack_keeps_ovf", 32'(overflow_cnt_o), 32'd2);

    // Flush with three entries queued and a concurrent push
    for (int i = 0; i < 3; i++) push_word(words[i], 1'b0);
    applyStimulus(1'b0, 1'b1, words[3], 1'b0, 1'b1, 1'b0);
    checkOutput("t5_flush_ready", 32'(bus.stage_slave_ready), 32'd0);
    idle(1'b1);
    checkOutput("t5_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    checkOutput("t5_ready", 32'(bus.stage_slave_ready), 32'd1);
    checkOutput("t5_exc_valid", 32'(exception_valid_o), 32'd0);
    checkOutput("t5_overflow", 32'(overflow_cnt_o), 32'd0);
    idle(1'b1);
    checkOutput("t5_push_discarded", 32'(bus.rsp_valid_o), 32'd0);

    // Statistics: 3 allowed, 2 denied (one skip, one fault), kept across flush
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_word(words[i], 1'b1);
    push_word(make_word(1'b1, MPT_WALKING_SKIP, 1'b0, NO_ERROR, 25'h44), 1'b1);
    push_word(f2, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
`ifdef MPT_RSP_STATS_EN
    checkOutput("t6_stat_allow", stat_allow_cnt_o, 32'd3);
    checkOutput("t6_stat_deny", stat_deny_cnt_o, 32'd2);
`else
    checkOutput("t6_stat_allow_off", stat_allow_cnt_o, 32'd0);
    checkOutput("t6_stat_deny_off", stat_deny_cnt_o, 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
`ifdef MPT_RSP_STATS_EN
    checkOutput("t6_allow_after_flush", stat_allow_cnt_o, 32'd3);
    checkOutput("t6_deny_after_flush", stat_deny_cnt_o, 32'd2);
`else
    checkOutput("t6_allow_after_flush_off", stat_allow_cnt_o, 32'd0);
    checkOutput("t6_deny_after_flush_off", stat_deny_cnt_o, 32'd0);
`endif

    // Random traffic, alternating eager and sluggish requester phases
    for (int c = 0; c < 3000; c++) begin
      bit rr;
      rr = ((c / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 2) != 0, random_word(),
                    rr, $urandom_range(0, 79) == 0, $urandom_range(0, 7) == 0);
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
